// File: rtl/fu_mul_pipe.sv
// rtl/fu_mul_pipe.sv - parametrised multi-cycle multiplier functional unit with tag and flush
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   flush           kills every in-flight op at the next edge
//   EN              issue request, taken when ready=1 and flush=0
//   op              00 MUL, 01 MULH (s*s), 10 MULHSU (s*u), 11 MULHU (u*u)
//   A, B            operands rs1 / rs2
//   tag_in          destination tag carried alongside the op
//   ready           FU can accept an op this cycle
//   res, tag_out    result and tag, meaningful only while finish=1
//   finish          one-cycle result-valid pulse, LATENCY cycles after accept

module fu_mul_pipe #(
  parameter int WIDTH     = 32,
  parameter int LATENCY   = 7,
  parameter int TAG_W     = 4,
  parameter int PIPELINED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             EN,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [TAG_W-1:0] tag_in,
  output logic             ready,
  output logic [WIDTH-1:0] res,
  output logic [TAG_W-1:0] tag_out,
  output logic             finish
);

  // Stages 1..NS form the shift chain; the output registers are stage LATENCY.
  localparam int NS = LATENCY - 1;
  localparam int PW = 2 * WIDTH;

  logic [NS:1]      vld_q, vld_d;
  logic [WIDTH-1:0] data_q [1:NS];
  logic [WIDTH-1:0] data_d [1:NS];
  logic [TAG_W-1:0] tag_q  [1:NS];
  logic [TAG_W-1:0] tag_d  [1:NS];

  logic             finish_q, finish_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;

  logic             a_sx, b_sx;
  logic [PW-1:0]    a_ext, b_ext, prod;
  logic [WIDTH-1:0] mul_res;
  logic             busy;
  logic             accept;

  // The low 2*WIDTH bits of the (WIDTH+1)-bit extended product are all that any
  // mode returns, and they are identical modulo 2^(2*WIDTH) whether the operands
  // are extended to WIDTH+1 or straight to 2*WIDTH bits.
  always_comb begin
    a_sx    = (op == 2'b01 || op == 2'b10) & A[WIDTH-1];
    b_sx    = (op == 2'b01) & B[WIDTH-1];
    a_ext   = {{WIDTH{a_sx}}, A};
    b_ext   = {{WIDTH{b_sx}}, B};
    prod    = a_ext * b_ext;
    mul_res = (op == 2'b00) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
  end

  // The finish cycle still counts as in flight for the non-pipelined unit.
  assign busy   = (|vld_q) | finish_q;
  assign ready  = rst_n & ((PIPELINED != 0) | ~busy);
  assign accept = EN & ready & ~flush;

  always_comb begin
    vld_d     = '0;
    data_d    = data_q;
    tag_d     = tag_q;
    vld_d[1]  = accept;
    if (accept) begin
      data_d[1] = mul_res;
      tag_d[1]  = tag_in;
    end
    for (int i = 2; i <= NS; i++) begin
      vld_d[i]  = vld_q[i-1] & ~flush;
      data_d[i] = data_q[i-1];
      tag_d[i]  = tag_q[i-1];
    end
    // A pulse already on the outputs during flush stands; the op behind it dies.
    finish_d  = vld_q[NS] & ~flush;
    res_d     = finish_d ? data_q[NS] : res_q;
    tag_out_d = finish_d ? tag_q[NS] : tag_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      for (int i = 1; i <= NS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      finish_q  <= 1'b0;
      res_q     <= '0;
      tag_out_q <= '0;
    end else begin
      vld_q     <= vld_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      finish_q  <= finish_d;
      res_q     <= res_d;
      tag_out_q <= tag_out_d;
    end
  end

  assign finish  = finish_q;
  assign res     = res_q;
  assign tag_out = tag_out_q;

endmodule

// File: tb/tb_fu_mul_pipe.sv
// tb/tb_fu_mul_pipe.sv - scoreboard bench for fu_mul_pipe, non-pipelined and pipelined instances

module tb_fu_mul_pipe;

  localparam int W  = 32;
  localparam int L  = 7;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          en0 = 1'b0;
  logic          en1 = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [TW-1:0] tag = '0;

  logic          rdy0, rdy1, fin0, fin1;
  logic [W-1:0]  res0, res1;
  logic [TW-1:0] to0, to1;

  typedef struct {
    logic [W-1:0]  r;
    logic [TW-1:0] t;
    int            due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   m0_from = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  fu_mul_pipe #(.WIDTH(W), .LATENCY(L), .TAG_W(TW), .PIPELINED(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .EN(en0), .op(op), .A(a), .B(b),
    .tag_in(tag), .ready(rdy0), .res(res0), .tag_out(to0), .finish(fin0)
  );

  fu_mul_pipe #(.WIDTH(W), .LATENCY(L), .TAG_W(TW), .PIPELINED(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .EN(en1), .op(op), .A(a), .B(b),
    .tag_in(tag), .ready(rdy1), .res(res1), .tag_out(to1), .finish(fin1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [W-1:0] mul_model(input logic [1:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    logic signed [2*W+1:0] ex, ey, p;
    ex = (o == 2'b01 || o == 2'b10) ? $signed({{(W+2){x[W-1]}}, x}) : $signed({{(W+2){1'b0}}, x});
    ey = (o == 2'b01) ? $signed({{(W+2){y[W-1]}}, y}) : $signed({{(W+2){1'b0}}, y});
    p  = ex * ey;
    return (o == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  // Reference model: decides acceptance from the inputs and pushes expectations.
  always @(posedge clk) begin
    exp_t dmy;
    if (rst_n) begin
      if (flush) begin
        while (q0.size() > 0 && q0[$].due > cyc) dmy = q0.pop_back();
        while (q1.size() > 0 && q1[$].due > cyc) dmy = q1.pop_back();
        if (m0_from > cyc + 1) m0_from = cyc + 1;
      end else begin
        if (en0 && cyc >= m0_from) begin
          q0.push_back('{mul_model(op, a, b), tag, cyc + L});
          m0_from = cyc + L + 1;
        end
        if (en1) q1.push_back('{mul_model(op, a, b), tag, cyc + L});
      end
    end
    cyc++;
  end

  always @(negedge rst_n) begin
    q0.delete();
    q1.delete();
    m0_from = 0;
  end

  task automatic scb0();
    exp_t e;
    if (fin0) begin
      if (q0.size() == 0) check("spurious_finish0", 1, 0);
      else begin
        e = q0.pop_front();
        check("res0", res0, e.r);
        check("tag0", to0, e.t);
        check("due0", cyc, e.due);
      end
    end else if (q0.size() > 0 && q0[0].due <= cyc) begin
      check("missed_finish0", 0, 1);
      e = q0.pop_front();
    end
  endtask

  task automatic scb1();
    exp_t e;
    if (fin1) begin
      if (q1.size() == 0) check("spurious_finish1", 1, 0);
      else begin
        e = q1.pop_front();
        check("res1", res1, e.r);
        check("tag1", to1, e.t);
        check("due1", cyc, e.due);
      end
    end else if (q1.size() > 0 && q1[0].due <= cyc) begin
      check("missed_finish1", 0, 1);
      e = q1.pop_front();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("ready0", rdy0, cyc >= m0_from);
      check("ready1", rdy1, 1);
      scb0();
      scb1();
    end
  end

  task automatic step(input logic e0, input logic e1, input logic fl, input logic [1:0] o,
                      input logic [W-1:0] x, input logic [W-1:0] y, input logic [TW-1:0] tg);
    en0 = e0; en1 = e1; flush = fl; op = o; a = x; b = y; tag = tg;
    @(posedge clk);
    #1;
    en0 = 1'b0; en1 = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_finish0"}, fin0, 0);
    check({pfx, "_res0"}, res0, 0);
    check({pfx, "_tag0"}, to0, 0);
    check({pfx, "_finish1"}, fin1, 0);
    check({pfx, "_res1"}, res1, 0);
    check({pfx, "_tag1"}, to1, 0);
  endtask

  initial begin
    #2;
    check_zero_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single op on the non-pipelined unit
    step(1, 0, 0, 2'b00, 32'd7, 32'd6, 4'd3);
    idle(10);

    // mode coverage on the pipelined unit
    step(0, 1, 0, 2'b00, 32'hFFFF_FFFF, 32'd2, 4'd1);
    step(0, 1, 0, 2'b01, 32'hFFFF_FFFF, 32'd2, 4'd2);
    step(0, 1, 0, 2'b10, 32'hFFFF_FFFF, 32'd2, 4'd3);
    step(0, 1, 0, 2'b11, 32'hFFFF_FFFF, 32'd2, 4'd4);
    step(0, 1, 0, 2'b01, 32'h8000_0000, 32'h8000_0000, 4'd5);
    idle(10);

    // EN held high on the non-pipelined unit: only every LATENCY+1 cycles taken
    for (int i = 0; i < 16; i++)
      step(1, 0, 0, 2'(i % 4), 32'(i * 1000 + 17), 32'(32'hF000_0000 + i), 4'(i));
    idle(10);

    // back-to-back pipelined issue
    step(0, 1, 0, 2'b00, 32'd2, 32'd3, 4'd1);
    step(0, 1, 0, 2'b00, 32'd4, 32'd5, 4'd2);
    step(0, 1, 0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3);
    idle(10);

    // flush kills in-flight ops and wins over EN; issue resumes the next cycle
    step(1, 1, 0, 2'b00, 32'd11, 32'd12, 4'd1);
    step(0, 1, 0, 2'b00, 32'd13, 32'd14, 4'd2);
    idle(1);
    step(1, 1, 1, 2'b00, 32'd5, 32'd5, 4'd4);
    step(1, 1, 0, 2'b00, 32'd9, 32'd9, 4'd6);
    idle(10);

    // flush in the cycle the oldest op finishes: that pulse stands
    step(0, 1, 0, 2'b11, 32'd100, 32'd3, 4'd7);
    step(0, 1, 0, 2'b00, 32'd101, 32'd3, 4'd8);
    step(0, 1, 0, 2'b00, 32'd102, 32'd3, 4'd9);
    idle(4);
    step(0, 0, 1, 2'b00, 32'd0, 32'd0, 4'd0);
    idle(10);

    // random traffic on both units
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
           2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)));
    idle(10);

    // asynchronous reset mid-operation
    step(1, 1, 0, 2'b00, 32'd123, 32'd456, 4'd7);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 1, 0, 2'b10, 32'(-5), 32'd7, 4'd9);
    idle(10);

    check("drain0", q0.size(), 0);
    check("drain1", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
